// File: rtl/alu_issue_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : alu_issue_sequencer
// Purpose  : Multicycle initiator for the MIPS ALU. Fetches 32-bit words from
//            instruction memory, reads operands from a 32x32 register file,
//            presents the instruction to the ALU, captures result/flags and
//            then writes back or redirects the PC.
// Ports    : clk/rst_n (async active-low) ; start pulse ;
//            imem_req/imem_addr/imem_valid/imem_rdata fetch port ;
//            alu_instruction/alu_regA/alu_regB to ALU, alu_result/alu_flags
//            back ; busy/done/ovf_err/illegal/retired status ;
//            dbg_addr/dbg_data combinational register-file read port.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_sequencer #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     alu_instruction,
    output logic [31:0]     alu_regA,
    output logic [31:0]     alu_regB,
    input  logic [31:0]     alu_result,
    input  logic [2:0]      alu_flags,
    output logic            busy,
    output logic            done,
    output logic            ovf_err,
    output logic            illegal,
    output logic [31:0]     retired,
    input  logic [4:0]      dbg_addr,
    output logic [31:0]     dbg_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_CAPT  = 3'd4;
    localparam logic [2:0] S_WB    = 3'd5;
    localparam logic [2:0] S_HALT  = 3'd6;

    logic [2:0]      r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [31:0]     r_alu_instr, r_alu_a, r_alu_b;
    logic [31:0]     r_res;
    logic [2:0]      r_flags;
    logic [31:0]     r_retired;
    logic [31:0]     r_rf [0:31];

    // ---------------- decode of the held instruction ----------------
    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd, w_dst;
    logic [15:0] w_imm;
    logic        w_dst_en, w_is_slt, w_ovf_chk, w_is_beq, w_is_bne, w_is_halt, w_legal;

    assign w_op  = r_ir[31:26];
    assign w_fn  = r_ir[5:0];
    assign w_rs  = r_ir[25:21];
    assign w_rt  = r_ir[20:16];
    assign w_rd  = r_ir[15:11];
    assign w_imm = r_ir[15:0];

    always_comb begin
        w_dst_en  = 1'b0;
        w_dst     = w_rd;
        w_is_slt  = 1'b0;
        w_ovf_chk = 1'b0;
        w_is_beq  = 1'b0;
        w_is_bne  = 1'b0;
        w_is_halt = 1'b0;
        w_legal   = 1'b1;
        case (w_op)
            6'h00: begin
                case (w_fn)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27: w_dst_en = 1'b1;
                    6'h20, 6'h22: begin
                        w_dst_en  = 1'b1;
                        w_ovf_chk = 1'b1;
                    end
                    6'h2A, 6'h2B: begin
                        w_dst_en = 1'b1;
                        w_is_slt = 1'b1;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            6'h08: begin
                w_dst_en  = 1'b1;
                w_dst     = w_rt;
                w_ovf_chk = 1'b1;
            end
            6'h09, 6'h0C, 6'h0D, 6'h0E: begin
                w_dst_en = 1'b1;
                w_dst    = w_rt;
            end
            6'h0A, 6'h0B: begin
                w_dst_en = 1'b1;
                w_dst    = w_rt;
                w_is_slt = 1'b1;
            end
            6'h04:   w_is_beq  = 1'b1;
            6'h05:   w_is_bne  = 1'b1;
            6'h3F:   w_is_halt = 1'b1;
            default: w_legal   = 1'b0;
        endcase
    end

    logic            w_ovf, w_wen, w_taken;
    logic [31:0]     w_wdata;
    logic [PC_W-1:0] w_pc4, w_boff, w_pc_nxt;

    assign w_ovf    = w_ovf_chk & r_flags[0];
    // Illegal words never reach here with w_dst_en set, so no extra gating.
    assign w_wen    = (r_state == S_WB) & w_dst_en & ~w_ovf & (w_dst != 5'd0);
    assign w_wdata  = w_is_slt ? {31'b0, r_flags[1]} : r_res;
    assign w_taken  = (w_is_beq & r_flags[2]) | (w_is_bne & ~r_flags[2]);
    assign w_pc4    = r_pc + PC_W'(3'd4);
    assign w_boff   = PC_W'({{14{w_imm[15]}}, w_imm, 2'b00});
    assign w_pc_nxt = w_taken ? (w_pc4 + w_boff) : w_pc4;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_HALT: if (start) w_state_nxt = S_FETCH;
            S_FETCH:        if (imem_valid) w_state_nxt = S_READ;
            S_READ:         w_state_nxt = S_EXEC;
            S_EXEC:         w_state_nxt = S_CAPT;
            S_CAPT:         w_state_nxt = S_WB;
            S_WB:           w_state_nxt = w_is_halt ? S_HALT : S_FETCH;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        imem_req = (r_state == S_FETCH);
        busy     = (r_state == S_FETCH) | (r_state == S_READ) | (r_state == S_EXEC) |
                   (r_state == S_CAPT)  | (r_state == S_WB);
        done     = (r_state == S_HALT);
        ovf_err  = (r_state == S_WB) & w_ovf;
        illegal  = (r_state == S_WB) & ~w_legal;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_alu_instr <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_res       <= '0;
            r_flags     <= '0;
            r_retired   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        r_pc      <= RESET_PC;
                        r_retired <= '0;
                    end
                end
                S_FETCH: if (imem_valid) r_ir <= imem_rdata;
                S_READ: begin
                    // Steer register fields so the ALU reads rs from regA and rt from regB.
                    r_alu_instr <= {r_ir[31:26], 5'b00000, 5'b00001, r_ir[15:0]};
                    r_alu_a     <= r_rf[w_rs];
                    r_alu_b     <= r_rf[w_rt];
                end
                S_CAPT: begin
                    r_res   <= alu_result;
                    r_flags <= alu_flags;
                end
                S_WB: begin
                    r_retired <= r_retired + 32'd1;
                    r_pc      <= w_pc_nxt;
                end
                default: ;
            endcase
        end
    end

    // Register file; R0 is never written so it always reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else if (w_wen) begin
            r_rf[w_dst] <= w_wdata;
        end
    end

    assign imem_addr       = r_pc;
    assign alu_instruction = r_alu_instr;
    assign alu_regA        = r_alu_a;
    assign alu_regB        = r_alu_b;
    assign retired         = r_retired;
    assign dbg_data        = r_rf[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_alu_issue_sequencer
// Purpose  : Scoreboard bench for alu_issue_sequencer with a behavioural
//            instruction memory and combinational ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        imem_req, imem_valid;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] alu_instruction, alu_regA, alu_regB, alu_result;
    logic [2:0]  alu_flags;
    logic        busy, done, ovf_err, illegal;
    logic [31:0] retired;
    logic [4:0]  dbg_addr = 5'd0;
    logic [31:0] dbg_data;

    always #5 clk = ~clk;

    alu_issue_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .alu_instruction(alu_instruction), .alu_regA(alu_regA), .alu_regB(alu_regB),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .busy(busy), .done(done), .ovf_err(ovf_err), .illegal(illegal),
        .retired(retired), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // ---------------- instruction memory ----------------
    localparam logic [31:0] HALT = 32'hFC00_0000;
    logic [31:0] imem [0:16383];
    int stall = 0;
    int wcnt  = 0;
    assign imem_valid = imem_req && (wcnt >= stall);
    assign imem_rdata = imem[imem_addr[15:2]];
    always @(posedge clk) begin
        if (!imem_req || imem_valid) wcnt <= 0;
        else                         wcnt <= wcnt + 1;
    end

    // ---------------- ALU model ----------------
    always_comb begin
        logic [5:0]  op, fn;
        logic [4:0]  sh;
        logic [31:0] a, b, se, ze, r;
        logic        lt, ov;
        op = alu_instruction[31:26];
        fn = alu_instruction[5:0];
        sh = alu_instruction[10:6];
        a  = alu_regA;
        b  = alu_regB;
        se = {{16{alu_instruction[15]}}, alu_instruction[15:0]};
        ze = {16'h0, alu_instruction[15:0]};
        r  = 32'h0;
        lt = 1'b0;
        ov = 1'b0;
        case (op)
            6'h00: case (fn)
                6'h00: r = b << sh;
                6'h02: r = b >> sh;
                6'h03: r = $unsigned($signed(b) >>> sh);
                6'h04: r = b << a[4:0];
                6'h06: r = b >> a[4:0];
                6'h07: r = $unsigned($signed(b) >>> a[4:0]);
                6'h20: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
                6'h21: r = a + b;
                6'h22: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
                6'h23: r = a - b;
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2A: begin lt = $signed(a) < $signed(b); r = {31'b0, lt}; end
                6'h2B: begin lt = a < b; r = {31'b0, lt}; end
                default: r = 32'h0;
            endcase
            6'h08: begin r = a + se; ov = (a[31] == se[31]) && (r[31] != a[31]); end
            6'h09: r = a + se;
            6'h0A: begin lt = $signed(a) < $signed(se); r = {31'b0, lt}; end
            6'h0B: begin lt = a < se; r = {31'b0, lt}; end
            6'h0C: r = a & ze;
            6'h0D: r = a | ze;
            6'h0E: r = a ^ ze;
            6'h04, 6'h05: r = a - b;
            default: r = 32'h0;
        endcase
        alu_result = r;
        alu_flags  = {(r == 32'h0), lt, ov};
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_addr [$];
    logic [1:0]  exp_evt  [$];   // 2 = overflow, 1 = illegal

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // Monitor: every accepted fetch and every status pulse is matched in order.
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req && imem_valid) begin
                if (exp_addr.size() == 0) chk("fetch_unexpected", {16'h0, imem_addr}, 32'hDEAD0000);
                else                      chk("fetch_addr", {16'h0, imem_addr}, {16'h0, exp_addr.pop_front()});
            end
            if (ovf_err || illegal) begin
                if (exp_evt.size() == 0) chk("event_unexpected", {30'h0, ovf_err, illegal}, 32'hDEAD0000);
                else                     chk("event", {30'h0, ovf_err, illegal}, {30'h0, exp_evt.pop_front()});
            end
        end
    end

    function automatic logic [31:0] ienc(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] renc(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    task automatic rd_reg(input logic [4:0] a, input logic [31:0] exp, input string nm);
        dbg_addr = a;
        #1;
        chk(nm, dbg_data, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 16384; i++) imem[i] = HALT;
        exp_addr.delete();
        exp_evt.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_alu_instr", alu_instruction, 32'h0);
        chk("rst_retired", retired, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_prog(input int exp_ret, input int exp_busy, input string nm);
        int cyc = 0;
        int guard = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (!done && guard < 3000) begin
            if (busy) cyc++;
            @(posedge clk); #1;
            guard++;
        end
        chk({nm, "_timeout"}, {31'h0, guard < 3000}, 32'h1);
        chk({nm, "_done"}, {30'h0, done, busy}, 32'h2);
        chk({nm, "_retired"}, retired, exp_ret);
        if (exp_busy >= 0) chk({nm, "_cycles"}, cyc, exp_busy);
        @(negedge clk);
        chk({nm, "_addr_left"}, exp_addr.size(), 0);
        chk({nm, "_evt_left"}, exp_evt.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: basic add, 5 cycles per instruction
        do_reset();
        stall = 0;
        imem[0] = ienc(6'h08, 0, 1, 16'd5);
        imem[1] = ienc(6'h08, 0, 2, 16'd7);
        imem[2] = renc(1, 2, 3, 0, 6'h20);
        exp_addr = '{16'h0, 16'h4, 16'h8, 16'hC};
        run_prog(4, 20, "t1");
        rd_reg(1, 32'd5, "t1_r1");
        rd_reg(2, 32'd7, "t1_r2");
        rd_reg(3, 32'd12, "t1_r3");

        // 2: signed overflow suppresses writeback
        do_reset();
        imem[0] = ienc(6'h08, 0, 1, 16'h7FFF);
        imem[1] = renc(0, 1, 1, 5'd16, 6'h00);
        imem[2] = ienc(6'h08, 1, 1, 16'h7FFF);
        imem[3] = renc(1, 1, 2, 0, 6'h20);
        exp_addr = '{16'h0, 16'h4, 16'h8, 16'hC, 16'h10};
        exp_evt  = '{2'd2};
        run_prog(5, 25, "t2");
        rd_reg(1, 32'h7FFF_7FFF, "t2_r1");
        rd_reg(2, 32'h0, "t2_r2");

        // 3: taken beq skips, bne not taken
        do_reset();
        imem[0] = ienc(6'h08, 0, 1, 16'd3);
        imem[1] = ienc(6'h04, 1, 1, 16'd2);
        imem[2] = ienc(6'h08, 0, 7, 16'd1);
        imem[3] = ienc(6'h08, 0, 7, 16'd1);
        imem[4] = ienc(6'h05, 1, 1, 16'hFFFF);
        exp_addr = '{16'h0, 16'h4, 16'h10, 16'h14};
        run_prog(4, 20, "t3");
        rd_reg(7, 32'h0, "t3_r7");

        // 3b: backward branch from pc 0 wraps to top of address space
        do_reset();
        imem[0] = ienc(6'h04, 0, 0, 16'hFFFE);
        exp_addr = '{16'h0, 16'hFFFC};
        run_prog(2, 10, "t3b");

        // 4: set-less-than and arithmetic shift, with 2 memory wait cycles
        do_reset();
        stall = 2;
        imem[0] = ienc(6'h08, 0, 1, 16'hFFFB);
        imem[1] = ienc(6'h0A, 1, 4, 16'hFFFF);
        imem[2] = ienc(6'h0B, 1, 5, 16'd1);
        imem[3] = ienc(6'h08, 0, 1, 16'hFFF6);
        imem[4] = renc(0, 1, 6, 5'd1, 6'h03);
        exp_addr = '{16'h0, 16'h4, 16'h8, 16'hC, 16'h10, 16'h14};
        run_prog(6, 42, "t4");
        stall = 0;
        rd_reg(4, 32'h1, "t4_r4");
        rd_reg(5, 32'h0, "t4_r5");
        rd_reg(6, 32'hFFFF_FFFB, "t4_r6");

        // 5: lw is illegal; writes to R0 discarded
        do_reset();
        imem[0] = ienc(6'h23, 0, 1, 16'h0);
        imem[1] = ienc(6'h08, 0, 0, 16'd9);
        exp_addr = '{16'h0, 16'h4, 16'h8};
        exp_evt  = '{2'd1};
        run_prog(3, 15, "t5");
        rd_reg(0, 32'h0, "t5_r0");
        rd_reg(1, 32'h0, "t5_r1");

        // 6: reset during EXEC of add, then restart
        do_reset();
        imem[0] = ienc(6'h08, 0, 1, 16'd1);
        imem[1] = renc(1, 1, 3, 0, 6'h20);
        exp_addr = '{16'h0, 16'h4};
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        begin
            int guard = 0;
            while (alu_instruction !== 32'h0001_1820 && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            chk("t6_reach_exec", {31'h0, guard < 200}, 32'h1);
        end
        rst_n = 1'b0;
        #1;
        chk("t6_busy", {31'h0, busy}, 32'h0);
        chk("t6_req", {31'h0, imem_req}, 32'h0);
        chk("t6_alu_instr", alu_instruction, 32'h0);
        chk("t6_alu_a", alu_regA, 32'h0);
        chk("t6_retired", retired, 32'h0);
        rd_reg(3, 32'h0, "t6_r3_abandoned");
        chk("t6_addr_left", exp_addr.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_addr = '{16'h0, 16'h4, 16'h8};
        run_prog(3, 15, "t6");
        rd_reg(3, 32'd2, "t6_r3");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
